game_sequencer: RTL

//  Top-level game-flow controller for the game console. Sequences title, play, life-lost,
//  win and game-over phases; drives the banner mux select (show_banner/banner_num) and

---
 rtl/game_sequencer_if.sv | 30 +++
 rtl/game_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/game_sequencer_if.sv
// Game-side signal bundle of the game-flow sequencer: frame/button/ball status in,
// banner select and engine control out.
interface game_sequencer_if #(
  parameter int NUM_IMAGES   = 4,
  parameter int ROUND_FRAMES = 3600
);
  localparam int BW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
  localparam int TW = $clog2(ROUND_FRAMES + 1);

  logic          i_frame_tick;
  logic          i_btn_start;
  logic          i_is_safe;
  logic          i_goal_reached;
  logic          o_show_banner;
  logic [BW-1:0] o_banner_num;
  logic          o_game_run;
  logic          o_game_reset;
  logic [3:0]    o_lives;
  logic [TW-1:0] o_time_left;

  modport slave (
    input  i_frame_tick, i_btn_start, i_is_safe, i_goal_reached,
    output o_show_banner, o_banner_num, o_game_run, o_game_reset, o_lives, o_time_left
  );

  modport master (
    output i_frame_tick, i_btn_start, i_is_safe, i_goal_reached,
    input  o_show_banner, o_banner_num, o_game_run, o_game_reset, o_lives, o_time_left
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: title, play, life-lost, win and game-over phases, with
// per-frame life and round-time bookkeeping. All outputs are registered.
module game_sequencer #(
  parameter int NUM_IMAGES        = 4,
  parameter int LIVES             = 3,
  parameter int ROUND_FRAMES      = 3600,
  parameter int BANNER_MIN_FRAMES = 60,
  parameter int UNSAFE_FRAMES     = 30
) (
  input  logic              clk,
  input  logic              arst_n,
  game_sequencer_if.slave   bus
);

  localparam int BW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
  localparam int TW = $clog2(ROUND_FRAMES + 1);
  localparam int HW = $clog2(BANNER_MIN_FRAMES + 1);
  localparam int UW = $clog2(UNSAFE_FRAMES + 1);

  localparam logic [BW-1:0] BANNER_TITLE = BW'(0);
  localparam logic [BW-1:0] BANNER_LOST  = BW'(1);
  localparam logic [BW-1:0] BANNER_WIN   = BW'(2);
  localparam logic [BW-1:0] BANNER_OVER  = BW'(3);
  localparam logic [TW-1:0] TIME_FULL    = TW'(ROUND_FRAMES);
  localparam logic [TW-1:0] TIME_ONE     = TW'(1);
  localparam logic [3:0]    LIVES_INIT   = 4'(LIVES);
  localparam logic [HW-1:0] HOLD_DONE    = HW'(BANNER_MIN_FRAMES);
  localparam logic [UW-1:0] UNSAFE_LAST  = UW'(UNSAFE_FRAMES - 1);

  typedef enum logic [2:0] {
    S_TITLE,
    S_PLAY,
    S_LIFE_LOST,
    S_WIN,
    S_GAME_OVER
  } state_t;

  state_t        state;
  logic          show_banner;
  logic [BW-1:0] banner_num;
  logic          game_run;
  logic          game_reset;
  logic [3:0]    lives;
  logic [TW-1:0] time_left;
  logic [HW-1:0] hold_cnt;
  logic [UW-1:0] unsafe_cnt;
  logic          btn_prev;

  logic press;
  logic hold_done;

  assign press     = bus.i_btn_start & ~btn_prev;
  assign hold_done = (hold_cnt == HOLD_DONE);

  // Every state entry below also clears hold_cnt, overriding the per-tick increment.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_TITLE;
      show_banner <= 1'b1;
      banner_num  <= BANNER_TITLE;
      game_run    <= 1'b0;
      game_reset  <= 1'b0;
      lives       <= LIVES_INIT;
      time_left   <= TIME_FULL;
      hold_cnt    <= '0;
      unsafe_cnt  <= '0;
      btn_prev    <= 1'b0;
    end else begin
      btn_prev   <= bus.i_btn_start;
      game_reset <= 1'b0;
      if (bus.i_frame_tick && !hold_done) begin
        hold_cnt <= hold_cnt + HW'(1);
      end

      case (state)
        S_TITLE: begin
          if (press && hold_done) begin
            state       <= S_PLAY;
            hold_cnt    <= '0;
            show_banner <= 1'b0;
            game_run    <= 1'b1;
            game_reset  <= 1'b1;
            lives       <= LIVES_INIT;
            time_left   <= TIME_FULL;
            unsafe_cnt  <= '0;
          end
        end

        S_PLAY: begin
          if (bus.i_frame_tick) begin
            if (bus.i_goal_reached) begin
              state       <= S_WIN;
              hold_cnt    <= '0;
              show_banner <= 1'b1;
              banner_num  <= BANNER_WIN;
              game_run    <= 1'b0;
            end else if (!bus.i_is_safe && unsafe_cnt == UNSAFE_LAST) begin
              state       <= S_LIFE_LOST;
              hold_cnt    <= '0;
              show_banner <= 1'b1;
              banner_num  <= BANNER_LOST;
              game_run    <= 1'b0;
              unsafe_cnt  <= '0;
              if (lives != 4'd0) begin
                lives <= lives - 4'd1;
              end
            end else if (time_left == TIME_ONE) begin
              state       <= S_GAME_OVER;
              hold_cnt    <= '0;
              show_banner <= 1'b1;
              banner_num  <= BANNER_OVER;
              game_run    <= 1'b0;
              time_left   <= '0;
            end else begin
              if (time_left != '0) begin
                time_left <= time_left - TIME_ONE;
              end
              unsafe_cnt <= bus.i_is_safe ? '0 : unsafe_cnt + UW'(1);
            end
          end
        end

        // Lives were already decremented on entry; resume play without a button press.
        S_LIFE_LOST: begin
          if (lives == 4'd0) begin
            state       <= S_GAME_OVER;
            hold_cnt    <= '0;
            show_banner <= 1'b1;
            banner_num  <= BANNER_OVER;
            game_run    <= 1'b0;
          end else if (hold_done) begin
            state       <= S_PLAY;
            hold_cnt    <= '0;
            show_banner <= 1'b0;
            game_run    <= 1'b1;
            game_reset  <= 1'b1;
          end
        end

        S_WIN, S_GAME_OVER: begin
          if (press && hold_done) begin
            state       <= S_TITLE;
            hold_cnt    <= '0;
            show_banner <= 1'b1;
            banner_num  <= BANNER_TITLE;
            game_run    <= 1'b0;
          end
        end

        default: begin
          state       <= S_TITLE;
          hold_cnt    <= '0;
          show_banner <= 1'b1;
          banner_num  <= BANNER_TITLE;
          game_run    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_show_banner = show_banner;
  assign bus.o_banner_num  = banner_num;
  assign bus.o_game_run    = game_run;
  assign bus.o_game_reset  = game_reset;
  assign bus.o_lives       = lives;
  assign bus.o_time_left   = time_left;

endmodule
